// File: rtl/ahb_ssram_responder_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and lane helpers for the
// on-chip SSRAM responder.
package ahb_ssram_responder_pkg;

  typedef enum logic [1:0] {
    AMBA_AHB_HTRANS_IDLE   = 2'b00,
    AMBA_AHB_HTRANS_BUSY   = 2'b01,
    AMBA_AHB_HTRANS_NONSEQ = 2'b10,
    AMBA_AHB_HTRANS_SEQ    = 2'b11
  } ahb_htrans_t;

  typedef enum logic [2:0] {
    AMBA_AHB_HSIZE_BYTE   = 3'd0,
    AMBA_AHB_HSIZE_HALF   = 3'd1,
    AMBA_AHB_HSIZE_WORD   = 3'd2,
    AMBA_AHB_HSIZE_DWORD  = 3'd3,
    AMBA_AHB_HSIZE_4WORD  = 3'd4,
    AMBA_AHB_HSIZE_8WORD  = 3'd5,
    AMBA_AHB_HSIZE_16WORD = 3'd6,
    AMBA_AHB_HSIZE_32WORD = 3'd7
  } ahb_hsize_t;

  typedef enum logic {
    AHB_RESP_OKAY  = 1'b0,
    AHB_RESP_ERROR = 1'b1
  } ahb_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } resp_state_t;

  // Anything wider than a word is treated as misaligned since the bus is 32 bits.
  function automatic logic ahb_unaligned(input logic [2:0] size, input logic [1:0] addr);
    logic result;
    case (size)
      AMBA_AHB_HSIZE_BYTE: result = 1'b0;
      AMBA_AHB_HSIZE_HALF: result = addr[0];
      AMBA_AHB_HSIZE_WORD: result = |addr;
      default:             result = 1'b1;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ahb_ssram_responder_lane_dec.sv
// Byte-lane decoder for 32-bit AHB targets: maps (size, addr[1:0]) to the
// written lanes, plus a misalignment flag for targets that signal ERROR.
module ahb_byte_lane_dec
  import ahb_ssram_responder_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] lane_mask,
  output logic       unaligned
);

  always_comb begin
    lane_mask = 4'b1111;
    case (size)
      AMBA_AHB_HSIZE_BYTE: lane_mask = 4'b0001 << addr;
      AMBA_AHB_HSIZE_HALF: lane_mask = addr[1] ? 4'b1100 : 4'b0011;
      default:             lane_mask = 4'b1111;
    endcase
    unaligned = ahb_unaligned(size, addr);
  end

endmodule

// File: rtl/ahb_ssram_responder.sv
// AHB-Lite SSRAM responder with programmable wait states and byte strobes.
// Define AHB_SSRAM_RESP_ERR_EN to answer misaligned/oversized accesses with ERROR.
module ahb_ssram_responder
  import ahb_ssram_responder_pkg::*;
#(
  parameter int AW          = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP
);

`ifdef AHB_SSRAM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int         DEPTH     = 2 ** (AW - 2);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  resp_state_t   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem [DEPTH];

  logic          active_trans;
  logic          accept;
  logic          req_err;
  logic          dat_err;
  logic          dat_unaligned;
  logic          wr_en;
  logic          rd_load;
  logic [3:0]    lane_mask;
  logic [31:0]   bit_mask;
  logic [AW-3:0] rd_word;
  logic [31:0]   mem_word;

  ahb_byte_lane_dec u_lane_dec (
    .size      (size_q),
    .addr      (addr_q[1:0]),
    .lane_mask (lane_mask),
    .unaligned (dat_unaligned)
  );

  assign bit_mask     = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
  assign active_trans = (HTRANS == AMBA_AHB_HTRANS_NONSEQ) || (HTRANS == AMBA_AHB_HTRANS_SEQ);
  // ERR1 deliberately refuses a new address phase; WAIT has HREADY low anyway.
  assign accept       = HSEL && HREADY && active_trans &&
                        ((state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2));
  assign req_err      = ERR_EN && ahb_unaligned(HSIZE, HADDR[1:0]);
  assign dat_err      = ERR_EN && dat_unaligned;
  assign wr_en        = (state_q == ST_DATA) && write_q && !HRESET;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      write_q    <= write_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    write_d    = write_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = dat_err ? ST_ERR1 : ST_DATA;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      addr_d  = HADDR;
      size_d  = HSIZE;
      write_d = HWRITE;
      if (WAIT_STATES == 0) begin
        state_d = req_err ? ST_ERR1 : ST_DATA;
      end else begin
        state_d    = ST_WAIT;
        wait_cnt_d = WAIT_LOAD;
      end
    end
  end

  // Read data is captured on the edge that enters DATA; with zero wait states that
  // edge can coincide with a completing write, so its lanes are forwarded.
  always_comb begin
    rd_load = 1'b0;
    rd_word = addr_q[AW-1:2];
    if (accept && (WAIT_STATES == 0) && !HWRITE && !req_err) begin
      rd_load = 1'b1;
      rd_word = HADDR[AW-1:2];
    end else if ((state_q == ST_WAIT) && (wait_cnt_q == 4'd0) && !write_q && !dat_err) begin
      rd_load = 1'b1;
    end
    mem_word = mem[rd_word];
    if (wr_en && (rd_word == addr_q[AW-1:2])) begin
      mem_word = (mem_word & ~bit_mask) | (HWDATA & bit_mask);
    end
    rdata_d = rd_load ? mem_word : rdata_q;
  end

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem[addr_q[AW-1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = AHB_RESP_OKAY;
    case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = AHB_RESP_ERROR;
      end
      ST_ERR2: HRESP = AHB_RESP_ERROR;
      default: ;
    endcase
    if (!ERR_EN) HRESP = AHB_RESP_OKAY;
  end

  assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_ssram_responder.sv
// Directed self-checking bench for ahb_ssram_responder with a read-data scoreboard;
// three instances cover 0, 3 and 4 wait states. Honours AHB_SSRAM_RESP_ERR_EN.
module tb_ahb_ssram_responder;
  import ahb_ssram_responder_pkg::*;

  logic        clk = 1'b0;
  logic        hreset;
  logic [2:0]  hsel;
  logic [11:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  wire  [2:0]  hready_o;
  wire  [2:0]  hresp;
  wire  [31:0] hrdata0, hrdata1, hrdata2;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] expQ[$];
  int          lowCycles;
  logic        respEnd;

  always #5 clk = ~clk;

  ahb_ssram_responder #(.AW(12), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_o[0]),
    .HREADYOUT(hready_o[0]), .HRDATA(hrdata0), .HRESP(hresp[0])
  );

  ahb_ssram_responder #(.AW(12), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_o[1]),
    .HREADYOUT(hready_o[1]), .HRDATA(hrdata1), .HRESP(hresp[1])
  );

  ahb_ssram_responder #(.AW(12), .WAIT_STATES(4)) u_ws4 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_o[2]),
    .HREADYOUT(hready_o[2]), .HRDATA(hrdata2), .HRESP(hresp[2])
  );

  function automatic logic [31:0] rdataOf(input int inst);
    case (inst)
      0:       return hrdata0;
      1:       return hrdata1;
      default: return hrdata2;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idleBus();
    hsel   = '0;
    htrans = AMBA_AHB_HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  // One non-pipelined transfer; for reads 'data' is the expected word.
  task automatic applyStimulus(input string tag, input int inst, input bit wr, input logic [11:0] addr,
                               input logic [2:0] size, input logic [31:0] data,
                               output int lowCnt, output logic respAtEnd);
    bit done;
    hsel       = '0;
    hsel[inst] = 1'b1;
    haddr      = addr;
    htrans     = AMBA_AHB_HTRANS_NONSEQ;
    hwrite     = wr;
    hsize      = size;
    if (!wr) expQ.push_back(data);
    @(posedge clk); #1;
    idleBus();
    if (wr) hwdata = data;
    lowCnt    = 0;
    respAtEnd = 1'b0;
    done      = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (hready_o[inst]) done = 1'b1;
      else begin
        lowCnt++;
        @(posedge clk); #1;
      end
    end
    testsRun++;
    assert (done) else begin
      testsFailed++;
      $error("[TB] FAIL %s timeout: observed %0d low cycles, expected completion", tag, lowCnt);
    end
    respAtEnd = hresp[inst];
    if (!wr) checkOutput({tag, " rdata"}, rdataOf(inst), expQ.pop_front());
    @(posedge clk); #1;
  endtask

  initial begin
    hreset = 1'b1;
    hwdata = '0;
    haddr  = '0;
    hsize  = AMBA_AHB_HSIZE_WORD;
    idleBus();
    repeat (3) @(posedge clk);
    #1 hreset = 1'b0;
    @(negedge clk);
    checkOutput("reset hready", {29'd0, hready_o}, 32'd7);
    checkOutput("reset hresp", {29'd0, hresp}, 32'd0);
    checkOutput("reset hrdata0", hrdata0, 32'd0);
    checkOutput("reset hrdata1", hrdata1, 32'd0);
    checkOutput("reset hrdata2", hrdata2, 32'd0);
    @(posedge clk); #1;

    applyStimulus("ws0 wr 010", 0, 1'b1, 12'h010, AMBA_AHB_HSIZE_WORD, 32'hDEADBEEF, lowCycles, respEnd);
    checkOutput("ws0 wr low", lowCycles, 0);
    applyStimulus("ws0 rd 010", 0, 1'b0, 12'h010, AMBA_AHB_HSIZE_WORD, 32'hDEADBEEF, lowCycles, respEnd);
    checkOutput("ws0 rd low", lowCycles, 0);
    checkOutput("ws0 rd resp", respEnd, 0);

    applyStimulus("ws0 wr 040", 0, 1'b1, 12'h040, AMBA_AHB_HSIZE_WORD, 32'h00000000, lowCycles, respEnd);
    applyStimulus("ws0 wb 041", 0, 1'b1, 12'h041, AMBA_AHB_HSIZE_BYTE, 32'h0000AA00, lowCycles, respEnd);
    applyStimulus("ws0 wh 042", 0, 1'b1, 12'h042, AMBA_AHB_HSIZE_HALF, 32'h12340000, lowCycles, respEnd);
    applyStimulus("ws0 rd 040", 0, 1'b0, 12'h040, AMBA_AHB_HSIZE_WORD, 32'h1234AA00, lowCycles, respEnd);

    // Write followed by a pipelined read of the same word.
    hsel   = 3'b001;
    haddr  = 12'h080;
    htrans = AMBA_AHB_HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = AMBA_AHB_HSIZE_WORD;
    @(posedge clk); #1;
    hwrite = 1'b0;
    hwdata = 32'h55667788;
    expQ.push_back(32'h55667788);
    @(posedge clk); #1;
    idleBus();
    @(negedge clk);
    checkOutput("b2b hready", hready_o[0], 1);
    checkOutput("b2b rdata", hrdata0, expQ.pop_front());
    @(posedge clk); #1;

    applyStimulus("ws0 wr 013", 0, 1'b1, 12'h013, AMBA_AHB_HSIZE_WORD, 32'h0BADF00D, lowCycles, respEnd);
`ifdef AHB_SSRAM_RESP_ERR_EN
    checkOutput("err low", lowCycles, 1);
    checkOutput("err resp", respEnd, 1);
    checkOutput("err hrdata hold", hrdata0, 32'h55667788);
    applyStimulus("err rd 010", 0, 1'b0, 12'h010, AMBA_AHB_HSIZE_WORD, 32'hDEADBEEF, lowCycles, respEnd);
`else
    checkOutput("unal low", lowCycles, 0);
    checkOutput("unal resp", respEnd, 0);
    checkOutput("unal hrdata hold", hrdata0, 32'h55667788);
    applyStimulus("unal rd 010", 0, 1'b0, 12'h010, AMBA_AHB_HSIZE_WORD, 32'h0BADF00D, lowCycles, respEnd);
`endif

    applyStimulus("ws3 wr 020", 1, 1'b1, 12'h020, AMBA_AHB_HSIZE_WORD, 32'hA5A50F0F, lowCycles, respEnd);
    checkOutput("ws3 wr low", lowCycles, 3);
    applyStimulus("ws3 rd 020", 1, 1'b0, 12'h020, AMBA_AHB_HSIZE_WORD, 32'hA5A50F0F, lowCycles, respEnd);
    checkOutput("ws3 rd low", lowCycles, 3);

    // BUSY must not open a data phase.
    hsel   = 3'b010;
    haddr  = 12'h024;
    htrans = AMBA_AHB_HTRANS_BUSY;
    @(posedge clk); #1;
    idleBus();
    @(negedge clk);
    checkOutput("busy hready", hready_o[1], 1);
    checkOutput("busy hresp", hresp[1], 0);
    @(posedge clk); #1;

    applyStimulus("ws4 wr 0c0", 2, 1'b1, 12'h0C0, AMBA_AHB_HSIZE_WORD, 32'h11112222, lowCycles, respEnd);
    checkOutput("ws4 wr low", lowCycles, 4);

    // Reset lands in the second wait cycle of a write.
    hsel   = 3'b100;
    haddr  = 12'h0C0;
    htrans = AMBA_AHB_HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = AMBA_AHB_HSIZE_WORD;
    @(posedge clk); #1;
    idleBus();
    hwdata = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("rst wait1 hready", hready_o[2], 0);
    @(posedge clk); #1;
    hreset = 1'b1;
    @(negedge clk);
    checkOutput("rst wait2 hready", hready_o[2], 0);
    @(posedge clk); #1;
    hreset = 1'b0;
    @(negedge clk);
    checkOutput("rst after hready", hready_o[2], 1);
    checkOutput("rst after hrdata0", hrdata0, 32'd0);
    @(posedge clk); #1;
    applyStimulus("ws4 rd 0c0", 2, 1'b0, 12'h0C0, AMBA_AHB_HSIZE_WORD, 32'h11112222, lowCycles, respEnd);
    checkOutput("ws4 rd low", lowCycles, 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
